ddr_cmd_gen: RTL and testbench
==============================

DDR_CMD_GEN -- requirements
Module: ddr_cmd_gen

Interface
REQ-001 Parameters (name, default, meaning):
- ADDRWIDTH, 17, DDR4 A bus width.
- BGWIDTH, 2, bank-group bits.
- BAWIDTH, 2, bank bits.
- COLWIDTH, 10, column bits.
- TRCD, 4, ACT to RD/WR cycles.
- TRP, 3, PRE to ACT/REF cycles.
- TRFC, 10, REF to next command cycles.
- All timing parameters are at least 1.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, sole clock; all logic on its rising edge.
- rst_n, in, 1, synchronous, active-low reset.
- req_valid, in, 1, request present.
- req_ready, out, 1, request accepted when high together with req_valid.
- req_op, in, 2, operation: 00 RD, 01 WR, 10 REF, 11 reserved (treated as REF).
- req_ap, in, 1, auto-precharge for RD/WR.
- req_bg, in, BGWIDTH, bank group.
- req_ba, in, BAWIDTH, bank.
- req_row, in, ADDRWIDTH, row address.
- req_col, in, COLWIDTH, column address.
- cs_n, out, 1, low only in a command cycle.
- act_n, out, 1, low only for ACT.
- cke, out, 1, clock enable.
- A, out, ADDRWIDTH, address/command pins.
- bg, out, BGWIDTH, bank group.
- ba, out, BAWIDTH, bank.
REQ-003 Clock is clk and reset is rst_n; there is one clock, and reset is synchronous and active-low.

Function
REQ-004 All DRAM-side outputs are registered and change only on the clk rising edge.
REQ-005 Command encoding (A16=RAS_n, A15=CAS_n, A14=WE_n, A10=AP):
- ACT: act_n=0, A=row.
- PRE: act_n=1, A16:14=010, A10=0.
- PREA: act_n=1, A16:14=010, A10=1.
- RD: act_n=1, A16:14=101.
- WR: act_n=1, A16:14=100.
- REF: act_n=1, A16:14=001, cke=1.
REQ-006 For RD/WR, A[COLWIDTH-1:0]=col, A10=ap, A12=1, and all other bits are 0.
REQ-007 Non-command cycles: cs_n=1, act_n=1, A all-ones, and bg/ba hold their last value.
REQ-008 Open-page tracking: one entry per bank (2^(BGWIDTH+BAWIDTH) entries), each holding an open flag and a row.
REQ-009 FSM states: IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, CAS, WAIT_AP, PREA, WAIT_RPA, REF, WAIT_RFC.
REQ-010 req_ready=1 only in IDLE; the request is captured on req_valid&&req_ready, and the captured fields are stable until return to IDLE.
REQ-011 RD/WR routing and latency (acceptance cycle = t):
- Row hit (bank open, same row): CAS issued at t+1.
- Bank closed: ACT at t+1, CAS at t+1+TRCD.
- Row miss: PRE at t+1, ACT at t+1+TRP, CAS at t+1+TRP+TRCD.
REQ-012 Timing gaps are exact: each wait state lasts precisely the parameter count minus one idle cycle between the two commands.
REQ-013 Table updates:
- ACT sets the bank open with the row.
- PRE clears the bank's open flag.
- CAS with ap=1 clears the bank and enters WAIT_AP for TRP cycles, then returns to IDLE.
- CAS with ap=0 returns to IDLE the next cycle.
REQ-014 REF handling:
- If any bank is open: PREA, then WAIT_RPA (TRP), then REF, then WAIT_RFC (TRFC), then IDLE.
- If no bank is open: REF at t+1.
- PREA clears all open flags.
REQ-015 The block issues at most one command per cycle, and req_ready stays low throughout every sequence.
REQ-016 req_valid while not ready is ignored, and request fields may change freely while req_ready=0.
REQ-017 req_valid with undefined fields in IDLE is still accepted; the block performs no protocol checking beyond REQ-011/014.

Reset
REQ-018 While rst_n=0:
- Outputs: cs_n=1, act_n=1, A all-ones, bg=0, ba=0, cke=0, req_ready=0.
- Internal: FSM in IDLE, all banks closed, wait counter 0.
REQ-019 After reset release: cke=1 and req_ready=1 from the first cycle after rst_n rises.
REQ-020 Reset asserted mid-sequence (including during a wait) aborts the sequence at the next edge with no further commands; any open-row state is discarded.

Verification
REQ-021 Bench covers these directed scenarios (TRCD=4, TRP=3, TRFC=10):
- RD bg=1 ba=2 row=0x155 col=0x3A ap=0 from reset: ACT A=0x155 at t+1, RD at t+5 with A[9:0]=0x3A and A10=0; req_ready high at t+6.
- Same bank, same row, WR col=0x10: WR at t+1 with A16:14=100.
- Same bank, row 0x2AA: PRE at t+1, ACT at t+4, WR at t+8.
- RD with ap=1: RD with A10=1, then req_ready low for 3 cycles; the next access to that bank issues ACT, not PRE.
- REF with 2 banks open: PREA at t+1 (A10=1), REF at t+4 (A16:14=001), req_ready high at t+14; the next RD to a previously open bank issues ACT first.
- rst_n low during WAIT_RCD: no CAS issued, outputs at reset values next cycle, cke=0.

Source files
------------

// File: rtl/ddr_cmd_gen.sv
// DDR4 command generator: turns RD/WR/REF requests into ACT/PRE/PREA/RD/WR/REF
// command cycles using a per-bank open-row table and fixed tRCD/tRP/tRFC gaps.
module ddr_cmd_gen #(
  parameter int ADDRWIDTH = 17,
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int COLWIDTH  = 10,
  parameter int TRCD      = 4,
  parameter int TRP       = 3,
  parameter int TRFC      = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic                 req_ap,
  input  logic [BGWIDTH-1:0]   req_bg,
  input  logic [BAWIDTH-1:0]   req_ba,
  input  logic [ADDRWIDTH-1:0] req_row,
  input  logic [COLWIDTH-1:0]  req_col,
  output logic                 cs_n,
  output logic                 act_n,
  output logic                 cke,
  output logic [ADDRWIDTH-1:0] A,
  output logic [BGWIDTH-1:0]   bg,
  output logic [BAWIDTH-1:0]   ba
);
  localparam int IDXW = BGWIDTH + BAWIDTH;
  localparam int NB   = 1 << IDXW;
  localparam int MAXT = (TRFC > TRCD) ? ((TRFC > TRP) ? TRFC : TRP)
                                      : ((TRCD > TRP) ? TRCD : TRP);
  localparam int CW   = $clog2(MAXT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_CAS,
    S_WAIT_AP, S_PREA, S_WAIT_RPA, S_REF, S_WAIT_RFC
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ready_q, cke_q, csN_q, actN_q;
  logic                  csN_d, actN_d;
  logic [ADDRWIDTH-1:0]  addr_q, addr_d;
  logic [BGWIDTH-1:0]    bg_q, bg_d;
  logic [BAWIDTH-1:0]    ba_q, ba_d;

  logic                  reqWr_q, reqAp_q;
  logic [BGWIDTH-1:0]    reqBg_q;
  logic [BAWIDTH-1:0]    reqBa_q;
  logic [ADDRWIDTH-1:0]  reqRow_q;
  logic [COLWIDTH-1:0]   reqCol_q;

  logic [NB-1:0]         openFlag_q;
  logic [ADDRWIDTH-1:0]  rowTbl_q [NB];

  logic                  accept, curWr, curAp;
  logic [BGWIDTH-1:0]    curBg;
  logic [BAWIDTH-1:0]    curBa;
  logic [ADDRWIDTH-1:0]  curRow;
  logic [COLWIDTH-1:0]   curCol;
  logic [IDXW-1:0]       reqIdx, curIdx;

  assign accept = req_valid && ready_q;
  assign reqIdx = {req_bg, req_ba};
  assign curIdx = {reqBg_q, reqBa_q};

  // On the accept edge the capture registers are not loaded yet, so the first command reads the inputs.
  always_comb begin
    if (state_q == S_IDLE) begin
      curWr = req_op[0]; curAp = req_ap; curBg = req_bg; curBa = req_ba;
      curRow = req_row; curCol = req_col;
    end else begin
      curWr = reqWr_q; curAp = reqAp_q; curBg = reqBg_q; curBa = reqBa_q;
      curRow = reqRow_q; curCol = reqCol_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (accept) begin
        if (req_op[1])
          state_d = (|openFlag_q) ? S_PREA : S_REF;
        else if (openFlag_q[reqIdx] && rowTbl_q[reqIdx] == req_row)
          state_d = S_CAS;
        else if (openFlag_q[reqIdx])
          state_d = S_PRE;
        else
          state_d = S_ACT;
      end
      S_PRE:      if (TRP > 1) begin state_d = S_WAIT_RP; cnt_d = CW'(TRP - 2); end
                  else state_d = S_ACT;
      S_WAIT_RP:  if (cnt_q == '0) state_d = S_ACT; else cnt_d = cnt_q - 1'b1;
      S_ACT:      if (TRCD > 1) begin state_d = S_WAIT_RCD; cnt_d = CW'(TRCD - 2); end
                  else state_d = S_CAS;
      S_WAIT_RCD: if (cnt_q == '0) state_d = S_CAS; else cnt_d = cnt_q - 1'b1;
      S_CAS:      if (reqAp_q) begin state_d = S_WAIT_AP; cnt_d = CW'(TRP - 1); end
                  else state_d = S_IDLE;
      S_WAIT_AP:  if (cnt_q == '0) state_d = S_IDLE; else cnt_d = cnt_q - 1'b1;
      S_PREA:     if (TRP > 1) begin state_d = S_WAIT_RPA; cnt_d = CW'(TRP - 2); end
                  else state_d = S_REF;
      S_WAIT_RPA: if (cnt_q == '0) state_d = S_REF; else cnt_d = cnt_q - 1'b1;
      S_REF:      if (TRFC > 1) begin state_d = S_WAIT_RFC; cnt_d = CW'(TRFC - 2); end
                  else state_d = S_IDLE;
      S_WAIT_RFC: if (cnt_q == '0) state_d = S_IDLE; else cnt_d = cnt_q - 1'b1;
      default:    state_d = S_IDLE;
    endcase
  end

  // Pin values are decoded from the state being entered so the command lands in that state's cycle.
  always_comb begin
    csN_d  = 1'b1;
    actN_d = 1'b1;
    addr_d = '1;
    bg_d   = bg_q;
    ba_d   = ba_q;
    case (state_d)
      S_ACT: begin
        csN_d = 1'b0; actN_d = 1'b0; addr_d = curRow; bg_d = curBg; ba_d = curBa;
      end
      S_PRE: begin
        csN_d = 1'b0; addr_d = '0; addr_d[16:14] = 3'b010; bg_d = curBg; ba_d = curBa;
      end
      S_PREA: begin
        csN_d = 1'b0; addr_d = '0; addr_d[16:14] = 3'b010; addr_d[10] = 1'b1;
      end
      S_CAS: begin
        csN_d = 1'b0;
        addr_d = '0;
        addr_d[COLWIDTH-1:0] = curCol;
        addr_d[10] = curAp;
        addr_d[12] = 1'b1;
        addr_d[16:14] = curWr ? 3'b100 : 3'b101;
        bg_d = curBg; ba_d = curBa;
      end
      S_REF: begin
        csN_d = 1'b0; addr_d = '0; addr_d[16:14] = 3'b001;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      cke_q   <= 1'b0;
      csN_q   <= 1'b1;
      actN_q  <= 1'b1;
      addr_q  <= '1;
      bg_q    <= '0;
      ba_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == S_IDLE);
      cke_q   <= 1'b1;
      csN_q   <= csN_d;
      actN_q  <= actN_d;
      addr_q  <= addr_d;
      bg_q    <= bg_d;
      ba_q    <= ba_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      reqWr_q  <= req_op[0];
      reqAp_q  <= req_ap;
      reqBg_q  <= req_bg;
      reqBa_q  <= req_ba;
      reqRow_q <= req_row;
      reqCol_q <= req_col;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      openFlag_q <= '0;
    end else begin
      case (state_q)
        S_ACT:   openFlag_q[curIdx] <= 1'b1;
        S_PRE:   openFlag_q[curIdx] <= 1'b0;
        S_CAS:   if (reqAp_q) openFlag_q[curIdx] <= 1'b0;
        S_PREA:  openFlag_q <= '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_ACT) rowTbl_q[curIdx] <= reqRow_q;
  end

  assign req_ready = ready_q;
  assign cke       = cke_q;
  assign cs_n      = csN_q;
  assign act_n     = actN_q;
  assign A         = addr_q;
  assign bg        = bg_q;
  assign ba        = ba_q;
endmodule

// File: tb/tb_ddr_cmd_gen.sv
// Bench for ddr_cmd_gen: directed and random requests compared cycle by cycle
// against a bank-table model that schedules commands from the timing rules.
module tb_ddr_cmd_gen;
  localparam int TRCD = 4;
  localparam int TRP  = 3;
  localparam int TRFC = 10;
  localparam int K_NOP = 0, K_ACT = 1, K_PRE = 2, K_PREA = 3, K_CAS = 4, K_REF = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic        req_ap = 1'b0;
  logic [1:0]  req_bg = 2'b00;
  logic [1:0]  req_ba = 2'b00;
  logic [16:0] req_row = 17'h0;
  logic [9:0]  req_col = 10'h0;
  logic        cs_n, act_n, cke;
  logic [16:0] A;
  logic [1:0]  bg, ba;

  always #5 clk = ~clk;

  ddr_cmd_gen #(
    .ADDRWIDTH(17), .BGWIDTH(2), .BAWIDTH(2), .COLWIDTH(10),
    .TRCD(TRCD), .TRP(TRP), .TRFC(TRFC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_ap(req_ap), .req_bg(req_bg), .req_ba(req_ba),
    .req_row(req_row), .req_col(req_col), .cs_n(cs_n), .act_n(act_n),
    .cke(cke), .A(A), .bg(bg), .ba(ba)
  );

  logic [24:0] bus;
  assign bus = {cs_n, act_n, A, bg, ba, req_ready, cke};

  int          checkCount = 0;
  int          passCount = 0;
  int          reqNum = 0;
  bit          modelOpen [16];
  logic [16:0] modelRow [16];
  logic [1:0]  lastBg = 2'b00;
  logic [1:0]  lastBa = 2'b00;

  task automatic checkOutput(input string tag, input logic [24:0] observed,
                             input logic [24:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [24:0] expBus(input int kind, input logic [16:0] row,
      input logic [9:0] col, input logic ap, input logic wr, input logic [1:0] b,
      input logic [1:0] k, input logic rdy);
    logic        csN, actN;
    logic [16:0] a;
    csN = 1'b1; actN = 1'b1; a = 17'h1FFFF;
    case (kind)
      K_ACT:  begin csN = 1'b0; actN = 1'b0; a = row; end
      K_PRE:  begin csN = 1'b0; a = 17'h0; a[16:14] = 3'b010; end
      K_PREA: begin csN = 1'b0; a = 17'h0; a[16:14] = 3'b010; a[10] = 1'b1; end
      K_CAS:  begin
        csN = 1'b0; a = 17'h0; a[9:0] = col; a[10] = ap; a[12] = 1'b1;
        a[16:14] = wr ? 3'b100 : 3'b101;
      end
      K_REF:  begin csN = 1'b0; a = 17'h0; a[16:14] = 3'b001; end
      default: ;
    endcase
    return {csN, actN, a, b, k, rdy, 1'b1};
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 16; i++) modelOpen[i] = 1'b0;
    lastBg = 2'b00;
    lastBa = 2'b00;
  endtask

  // Builds the expected command timeline from the bank table, then walks it with busy-time noise on the inputs.
  task automatic applyStimulus(input logic [1:0] op, input logic ap, input logic [1:0] bgv,
      input logic [1:0] bav, input logic [16:0] row, input logic [9:0] col);
    int kind [40];
    int readyOff, casOff, waitCnt, idx;
    bit anyOpen;
    waitCnt = 0;
    while (req_ready !== 1'b1 && waitCnt < 50) begin step(); waitCnt++; end
    reqNum++;
    checkOutput($sformatf("req%0d ready", reqNum), {24'h0, req_ready}, 25'h1);
    if (req_ready !== 1'b1) return;

    for (int k = 0; k < 40; k++) kind[k] = K_NOP;
    idx = int'({bgv, bav});
    anyOpen = 1'b0;
    for (int i = 0; i < 16; i++) if (modelOpen[i]) anyOpen = 1'b1;
    if (op[1]) begin
      if (anyOpen) begin
        kind[1] = K_PREA; kind[1 + TRP] = K_REF; readyOff = 1 + TRP + TRFC;
        for (int i = 0; i < 16; i++) modelOpen[i] = 1'b0;
      end else begin
        kind[1] = K_REF; readyOff = 1 + TRFC;
      end
    end else begin
      if (modelOpen[idx] && modelRow[idx] == row) casOff = 1;
      else if (modelOpen[idx]) begin
        kind[1] = K_PRE; kind[1 + TRP] = K_ACT; casOff = 1 + TRP + TRCD;
      end else begin
        kind[1] = K_ACT; casOff = 1 + TRCD;
      end
      kind[casOff] = K_CAS;
      readyOff = casOff + 1 + (ap ? TRP : 0);
      modelOpen[idx] = !ap;
      modelRow[idx] = row;
    end

    req_valid = 1'b1; req_op = op; req_ap = ap; req_bg = bgv; req_ba = bav;
    req_row = row; req_col = col;
    step();
    for (int k = 1; k <= readyOff; k++) begin
      if (kind[k] == K_ACT || kind[k] == K_PRE || kind[k] == K_CAS) begin
        lastBg = bgv; lastBa = bav;
      end
      checkOutput($sformatf("req%0d op%0d cyc%0d", reqNum, op, k), bus,
                  expBus(kind[k], row, col, ap, op[0], lastBg, lastBa, k == readyOff));
      if (k < readyOff) begin
        req_valid = 1'($urandom_range(0, 1));
        req_op = 2'($urandom); req_ap = 1'($urandom); req_bg = 2'($urandom);
        req_ba = 2'($urandom); req_row = 17'($urandom); req_col = 10'($urandom);
        step();
      end else begin
        req_valid = 1'b0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    logic [1:0] op;
    modelReset();
    rst_n = 1'b0;
    repeat (3) step();
    checkOutput("reset values", bus, {1'b1, 1'b1, 17'h1FFFF, 2'b00, 2'b00, 1'b0, 1'b0});
    rst_n = 1'b1;
    step();
    checkOutput("after release", bus, {1'b1, 1'b1, 17'h1FFFF, 2'b00, 2'b00, 1'b1, 1'b1});

    applyStimulus(2'b00, 1'b0, 2'd1, 2'd2, 17'h155, 10'h03A);
    applyStimulus(2'b01, 1'b0, 2'd1, 2'd2, 17'h155, 10'h010);
    applyStimulus(2'b01, 1'b0, 2'd1, 2'd2, 17'h2AA, 10'h020);
    applyStimulus(2'b00, 1'b1, 2'd1, 2'd2, 17'h2AA, 10'h030);
    applyStimulus(2'b00, 1'b0, 2'd1, 2'd2, 17'h2AA, 10'h031);
    applyStimulus(2'b00, 1'b0, 2'd0, 2'd1, 17'h007, 10'h3FF);
    applyStimulus(2'b10, 1'b0, 2'd0, 2'd0, 17'h000, 10'h000);
    applyStimulus(2'b00, 1'b0, 2'd1, 2'd2, 17'h2AA, 10'h002);
    applyStimulus(2'b11, 1'b0, 2'd3, 2'd3, 17'h1FFFF, 10'h3FF);

    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 9));
      op = (r < 4) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
      applyStimulus(op, ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 1)),
                    2'($urandom_range(0, 1)), 17'h100 + 17'($urandom_range(0, 2)),
                    10'($urandom));
    end

    applyStimulus(2'b10, 1'b0, 2'd0, 2'd0, 17'h0, 10'h0);
    req_valid = 1'b1; req_op = 2'b00; req_ap = 1'b0; req_bg = 2'd2; req_ba = 2'd3;
    req_row = 17'h0AB; req_col = 10'h005;
    step();
    req_valid = 1'b0;
    checkOutput("midrst act", bus, expBus(K_ACT, 17'h0AB, 10'h005, 1'b0, 1'b0, 2'd2, 2'd3, 1'b0));
    step();
    checkOutput("midrst rcd", bus, expBus(K_NOP, 17'h0, 10'h0, 1'b0, 1'b0, 2'd2, 2'd3, 1'b0));
    rst_n = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("midrst hold%0d", i), bus,
                  {1'b1, 1'b1, 17'h1FFFF, 2'b00, 2'b00, 1'b0, 1'b0});
      step();
    end
    rst_n = 1'b1;
    step();
    checkOutput("midrst release", bus, {1'b1, 1'b1, 17'h1FFFF, 2'b00, 2'b00, 1'b1, 1'b1});
    modelReset();
    applyStimulus(2'b00, 1'b0, 2'd2, 2'd3, 17'h0AB, 10'h005);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
